// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared types and helpers for the mux41 round-robin arbiter.
package mux41_arb_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] enc(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (oh[i]) r = IDX_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Requester/arbiter bundle. Optional lock input when MUX41_ARB_LOCK_EN is defined.
interface mux41_rr_arbiter_if #(parameter int HOLD_MAX = 8);
  import mux41_arb_pkg::*;
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic             s1;
  logic             s0;
  logic             busy;
  logic [CNT_W-1:0] tenure;
`ifdef MUX41_ARB_LOCK_EN
  logic             lock;

  modport master (output req, lock, input grant, s1, s0, busy, tenure);
  modport slave  (input req, lock, output grant, s1, s0, busy, tenure);
`else
  modport master (output req, input grant, s1, s0, busy, tenure);
  modport slave  (input req, output grant, s1, s0, busy, tenure);
`endif
endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational rotating priority search: first set req after 'last', wrapping,
// optionally skipping one index (the current owner).
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  input  logic             exclude_en,
  input  logic [IDX_W-1:0] exclude_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] cand;

  // Scan last+1 .. last+4 (mod 4); earliest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && req[cand] && !(exclude_en && cand == exclude_idx)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin owner of a 4:1 mux with max-tenure preemption.
// Optional feature macro: MUX41_ARB_LOCK_EN (owner lock suppresses preemption).
module mux41_rr_arbiter
  import mux41_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  localparam int CNT_W   = $clog2(HOLD_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  mux41_rr_arbiter_if.slave  bus
);
  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d;     // also owner index while in ST_OWN
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] tenure_q, tenure_d;
  logic             found;
  logic [IDX_W-1:0] win;
  logic             locked;

`ifdef MUX41_ARB_LOCK_EN
  assign locked = bus.lock;
`else
  assign locked = 1'b0;
`endif

  // Owner never competes against itself, so a handoff always rotates away.
  rr_pick4 u_pick (
    .req         (bus.req),
    .last        (last_q),
    .exclude_en  (state_q == ST_OWN),
    .exclude_idx (sel_q),
    .found       (found),
    .idx         (win)
  );

  // Next-state: grant on request, hand off on release or tenure expiry.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    last_d   = last_q;
    tenure_d = tenure_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_OWN;
          grant_d  = onehot(win);
          sel_d    = win;
          last_d   = win;
          tenure_d = CNT_W'(1);
        end
      end
      ST_OWN: begin
        if (!bus.req[sel_q] ||
            (tenure_q == CNT_W'(HOLD_MAX) && !locked && found)) begin
          if (found) begin
            grant_d  = onehot(win);
            sel_d    = win;
            last_d   = win;
            tenure_d = CNT_W'(1);
          end else begin
            // sel stays on old owner so the mux output stays put while idle
            state_d  = ST_IDLE;
            grant_d  = '0;
            tenure_d = '0;
          end
        end else if (tenure_q < CNT_W'(HOLD_MAX)) begin
          tenure_d = tenure_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      last_q   <= IDX_W'(NREQ - 1);
      tenure_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      tenure_q <= tenure_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.s1     = sel_q[1];
  assign bus.s0     = sel_q[0];
  assign bus.busy   = |grant_q;
  assign bus.tenure = tenure_q;
endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux output among four requesters.
- Registers a one-hot grant and drives the mux select pair (s1, s0) that steers the winning input to y.
- Sits directly in front of mux41: its s1/s0 outputs connect to the mux select inputs.
- Enforces a maximum tenure so that no single requester can starve the others.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one owner keeps the grant while another request is pending; legal range >= 1.
- CNT_W, $clog2(HOLD_MAX+1): tenure counter width; derived, not to be overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  input  4  request vector; req[i] held high for as long as requester i wants the mux.
- grant  output  4  one-hot grant, registered; all zeros when idle.
- s1  output  1  mux select MSB = owner index bit 1.
- s0  output  1  mux select LSB = owner index bit 0.
- busy  output  1  high when any grant bit is set (equals |grant).
- tenure  output  CNT_W  cycles the current owner has held the grant, saturating at HOLD_MAX.

Behaviour:
- Reset (rst_n low at a clock edge):
  - grant=4'b0000, s1=0, s0=0, busy=0, tenure=0, state=IDLE.
  - Round-robin pointer last=3, so requester 0 has highest priority first.
- FSM states: IDLE and OWN.
- Winner search: scan indices last+1, last+2, ... modulo 4 and pick the first set req bit, excluding the current owner where stated.
- IDLE:
  - If req!=0, at the next edge: grant=onehot(winner), {s1,s0}=winner, tenure=1, last=winner, go to OWN.
  - Grant latency is one cycle from req sampled to grant visible.
- OWN, owner=o:
  - Owner releases (req[o]=0):
    - If any other request is pending, hand off to the next winner at the next edge with no idle bubble; tenure=1.
    - Otherwise grant=0 and go to IDLE.
  - Owner holds and tenure==HOLD_MAX with another request pending: preempt, i.e. hand off to the next winner (excluding o) at the next edge.
  - Owner holds, otherwise: keep the grant and increment tenure, saturating at HOLD_MAX.
  - A lone requester keeps the grant indefinitely.
- Select hold in IDLE: {s1,s0} keeps the last owner index, so mux output y does not glitch between tenures. Only grant and busy indicate ownership.
- Simultaneous events:
  - Owner drops req in the same cycle new requests arrive: new requests take part in that cycle's search.
  - A request appearing in the same cycle as a preemption is eligible if it is next in rotation.
- Reset mid-tenure: the next edge with rst_n=0 forces reset values regardless of state; requests are re-arbitrated from last=3.
- Invariants:
  - grant is always zero or one-hot.
  - {s1,s0} equals the index of the set grant bit whenever busy=1.

Optional Feature:
- Macro MUX41_ARB_LOCK_EN adds input port lock (1 bit).
  - While lock=1 and the owner still requests, preemption is suppressed and tenure saturates.
  - Lock is ignored in IDLE and once the owner releases.
- Without the macro: no lock port; the HOLD_MAX preemption always applies.

Decomposition:
- Shared package mux41_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_OWN=1'b1;
  - NREQ=4 and the index width IDX_W=2;
  - functions onehot(idx) and enc(onehot).
- Sub-module rr_pick4 is natural: combinational, inputs req[3:0], last[1:0], exclude_en, exclude_idx; outputs found and idx[1:0].
- The top level instantiates rr_pick4 once and mux41 is not instantiated inside the block; integration wires s1/s0 externally.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0000, s1s0=00, busy=0, tenure=0; first edge after release -> grant=0001.
- Rotation: req=4'b1111 held, HOLD_MAX=8 -> grant sequence 0001,0010,0100,1000,0001, each held exactly 8 cycles, no idle cycle between tenures.
- Lone requester: req=4'b0100 for 20 cycles -> grant=0100 and s1s0=10 throughout; tenure saturates at 8; no preemption.
- Release and handoff: owner 1 drops req while req[3]=1 -> next edge grant=1000, tenure=1; req=0 afterwards -> grant=0000 and s1s0 holds 11.
- Mid-tenure reset: grant=0100 with tenure=5, assert rst_n=0 for one cycle with req=4'b0101 -> reset values; next winner is 0001, not 0100.
- Lock (MUX41_ARB_LOCK_EN): owner 0 with lock=1, req=4'b0011 for 15 cycles -> grant stays 0001; one edge after lock drops, with tenure saturated at 8 -> grant becomes 0010.
